// File: rtl/tutor_chk_pkg.sv
// rtl/tutor_chk_pkg.sv - shared constants and counter next-state helper for the counter checker
package tutor_chk_pkg;

  localparam int DEF_WIDTH     = 4;
  localparam int DEF_ERR_CNT_W = 8;

  localparam logic [1:0] ST_UNSYNC = 2'd0;
  localparam logic [1:0] ST_TRACK  = 2'd1;
  localparam logic [1:0] ST_HALT   = 2'd2;

  typedef logic [31:0] cnt_word_t;

  // Works on a full word; callers truncate to their width, which yields the modulo wrap.
  function automatic cnt_word_t next_count(input cnt_word_t cnt, input logic clr, input logic load,
                                           input logic ce, input logic dir, input cnt_word_t data);
    cnt_word_t nxt;
    if (clr)
      nxt = '0;
    else if (load)
      nxt = data;
    else if (ce && dir)
      nxt = cnt + 32'd1;
    else if (ce)
      nxt = cnt - 32'd1;
    else
      nxt = cnt;
    return nxt;
  endfunction

endpackage

// File: rtl/tutor_counter_model.sv
// rtl/tutor_counter_model.sv - reference counter and data latch producing the expected output
module tutor_counter_model
  import tutor_chk_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             dut_clr,
  input  logic             load,
  input  logic             ce,
  input  logic             dir,
  input  logic             sel,
  input  logic             le,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] exp_q
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] lat_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q <= '0;
      lat_q <= '0;
    end else begin
      cnt_q <= WIDTH'(next_count(cnt_word_t'(cnt_q), dut_clr, load, ce, dir, cnt_word_t'(data)));
      if (le)
        lat_q <= data;
    end
  end

  // A transparent latch passes DATA straight through in the same cycle.
  always_comb begin
    exp_q = cnt_q;
    if (sel)
      exp_q = le ? data : lat_q;
  end

endmodule

// File: rtl/tutor_counter_checker.sv
// rtl/tutor_counter_checker.sv - response checker comparing the counter output against a reference model
module tutor_counter_checker
  import tutor_chk_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int ERR_CNT_W   = DEF_ERR_CNT_W,
  parameter bit HALT_ON_ERR = 1'b0
) (
  input  logic                 CLK,
  input  logic                 CLR_N,
  input  logic                 EN,
  input  logic                 DUT_CLR,
  input  logic                 CE,
  input  logic                 LOAD,
  input  logic                 DIR,
  input  logic                 SEL,
  input  logic [WIDTH-1:0]     DATA,
  input  logic                 OE,
  input  logic                 LE,
  input  logic [WIDTH-1:0]     Q,
  output logic                 ERR,
  output logic                 ERR_STICKY,
  output logic [ERR_CNT_W-1:0] ERR_CNT,
  output logic [ERR_CNT_W-1:0] CHK_CNT,
  output logic [WIDTH-1:0]     EXP_FIRST,
  output logic [WIDTH-1:0]     OBS_FIRST,
  output logic                 SYNCED
);

  localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state;
  logic [WIDTH-1:0] exp_q;
  logic             cmp;
  logic             mis;

  tutor_counter_model #(.WIDTH(WIDTH)) u_model (
    .clk     (CLK),
    .clr_n   (CLR_N),
    .dut_clr (DUT_CLR),
    .load    (LOAD),
    .ce      (CE),
    .dir     (DIR),
    .sel     (SEL),
    .le      (LE),
    .data    (DATA),
    .exp_q   (exp_q)
  );

  // Clear and transparent-latch cycles have asynchronous paths in the counter, so they are skipped.
  assign cmp    = (state == ST_TRACK) && EN && OE && !DUT_CLR && !LE;
  assign mis    = cmp && (Q != exp_q);
  assign SYNCED = (state == ST_TRACK) || (state == ST_HALT);

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state <= ST_UNSYNC;
    end else begin
      case (state)
        ST_UNSYNC: if (DUT_CLR || LOAD) state <= ST_TRACK;
        ST_TRACK:  if (mis && HALT_ON_ERR) state <= ST_HALT;
        ST_HALT:   state <= ST_HALT;
        default:   state <= ST_UNSYNC;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      ERR        <= 1'b0;
      ERR_STICKY <= 1'b0;
      ERR_CNT    <= '0;
      CHK_CNT    <= '0;
      EXP_FIRST  <= '0;
      OBS_FIRST  <= '0;
    end else begin
      ERR <= mis;
      if (cmp && (CHK_CNT != CNT_MAX))
        CHK_CNT <= CHK_CNT + CNT_ONE;
      if (mis && (ERR_CNT != CNT_MAX))
        ERR_CNT <= ERR_CNT + CNT_ONE;
      if (mis && !ERR_STICKY) begin
        ERR_STICKY <= 1'b1;
        EXP_FIRST  <= exp_q;
        OBS_FIRST  <= Q;
      end
    end
  end

endmodule

// File: tb/tb_tutor_counter_checker.sv
// tb/tb_tutor_counter_checker.sv - self-checking bench for tutor_counter_checker
module tb_tutor_counter_checker;

  localparam int W    = 4;
  localparam int CW   = 8;
  localparam int CMAX = 255;

  logic CLK = 1'b0;
  logic CLR_N, EN, DUT_CLR, CE, LOAD, DIR, SEL, OE, LE;
  logic [W-1:0] DATA, Q;

  logic [1:0]    err_o, sticky_o, synced_o;
  logic [CW-1:0] ecnt_o [2];
  logic [CW-1:0] ccnt_o [2];
  logic [W-1:0]  efirst_o [2];
  logic [W-1:0]  ofirst_o [2];

  always #5 CLK = ~CLK;

  tutor_counter_checker #(.WIDTH(W), .ERR_CNT_W(CW), .HALT_ON_ERR(1'b0)) u_dut0 (
    .CLK(CLK), .CLR_N(CLR_N), .EN(EN), .DUT_CLR(DUT_CLR), .CE(CE), .LOAD(LOAD), .DIR(DIR),
    .SEL(SEL), .DATA(DATA), .OE(OE), .LE(LE), .Q(Q),
    .ERR(err_o[0]), .ERR_STICKY(sticky_o[0]), .ERR_CNT(ecnt_o[0]), .CHK_CNT(ccnt_o[0]),
    .EXP_FIRST(efirst_o[0]), .OBS_FIRST(ofirst_o[0]), .SYNCED(synced_o[0])
  );

  tutor_counter_checker #(.WIDTH(W), .ERR_CNT_W(CW), .HALT_ON_ERR(1'b1)) u_dut1 (
    .CLK(CLK), .CLR_N(CLR_N), .EN(EN), .DUT_CLR(DUT_CLR), .CE(CE), .LOAD(LOAD), .DIR(DIR),
    .SEL(SEL), .DATA(DATA), .OE(OE), .LE(LE), .Q(Q),
    .ERR(err_o[1]), .ERR_STICKY(sticky_o[1]), .ERR_CNT(ecnt_o[1]), .CHK_CNT(ccnt_o[1]),
    .EXP_FIRST(efirst_o[1]), .OBS_FIRST(ofirst_o[1]), .SYNCED(synced_o[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: instance 0 never halts, instance 1 halts on its first mismatch.
  int m_cnt, m_lat;
  bit m_sync;
  bit m_err [2];
  bit m_sticky [2];
  bit m_halt [2];
  int m_ecnt [2];
  int m_ccnt [2];
  int m_efirst [2];
  int m_ofirst [2];

  typedef struct {
    logic clr, load, ce, dir, sel, le, oe, en;
    int   data, q;
    int   e_err, e_ecnt, e_ccnt;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic int good_q();
    if (SEL)
      return LE ? int'(DATA) : m_lat;
    return m_cnt;
  endfunction

  task automatic model_reset();
    m_cnt  = 0;
    m_lat  = 0;
    m_sync = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_err[i] = 0; m_sticky[i] = 0; m_halt[i] = 0;
      m_ecnt[i] = 0; m_ccnt[i] = 0; m_efirst[i] = 0; m_ofirst[i] = 0;
    end
  endtask

  task automatic model_step();
    int e;
    bit cmp, mis;
    e = good_q();
    for (int i = 0; i < 2; i++) begin
      cmp = m_sync && !m_halt[i] && EN && OE && !DUT_CLR && !LE;
      mis = cmp && (int'(Q) != e);
      m_err[i] = mis;
      if (cmp && m_ccnt[i] < CMAX) m_ccnt[i]++;
      if (mis) begin
        if (m_ecnt[i] < CMAX) m_ecnt[i]++;
        if (!m_sticky[i]) begin
          m_sticky[i] = 1; m_efirst[i] = e; m_ofirst[i] = int'(Q);
        end
        if (i == 1) m_halt[i] = 1;
      end
    end
    if (DUT_CLR || LOAD) m_sync = 1'b1;
    if (DUT_CLR)      m_cnt = 0;
    else if (LOAD)    m_cnt = int'(DATA);
    else if (CE)      m_cnt = (m_cnt + (DIR ? 1 : 15)) % 16;
    if (LE) m_lat = int'(DATA);
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s.err%0d", tag, i),    int'(err_o[i]),    int'(m_err[i]));
      chk($sformatf("%s.sticky%0d", tag, i), int'(sticky_o[i]), int'(m_sticky[i]));
      chk($sformatf("%s.ecnt%0d", tag, i),   int'(ecnt_o[i]),   m_ecnt[i]);
      chk($sformatf("%s.ccnt%0d", tag, i),   int'(ccnt_o[i]),   m_ccnt[i]);
      chk($sformatf("%s.efirst%0d", tag, i), int'(efirst_o[i]), m_efirst[i]);
      chk($sformatf("%s.ofirst%0d", tag, i), int'(ofirst_o[i]), m_ofirst[i]);
      chk($sformatf("%s.synced%0d", tag, i), int'(synced_o[i]), int'(m_sync));
    end
  endtask

  task automatic ctl(input logic clr, input logic load, input logic ce, input logic dir,
                     input logic sel, input logic le, input logic oe, input logic en, input int data);
    DUT_CLR = clr; LOAD = load; CE = ce; DIR = dir;
    SEL = sel; LE = le; OE = oe; EN = en; DATA = W'(data);
  endtask

  task automatic tick(input string tag, input int q);
    Q = W'(q);
    @(posedge CLK);
    #1;
    model_step();
    check_all(tag);
  endtask

  // Called just after an edge; reset is asserted and released between edges.
  task automatic async_reset();
    #2 CLR_N = 1'b0;
    #1;
    model_reset();
    check_all("arst");
    chk("arst.synced", int'(synced_o[0]), 0);
    #1 CLR_N = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1,0,0,0,0,0,1,1, 0, 0, 0,0,0};
    tbl[1]  = '{0,0,0,0,1,1,1,1, 1, 1, 0,0,0};
    tbl[2]  = '{0,0,0,0,1,0,1,1, 5, 1, 0,0,1};
    tbl[3]  = '{0,0,0,0,1,0,1,1, 5, 5, 1,1,2};
    tbl[4]  = '{0,0,0,0,1,0,1,1, 5, 1, 0,1,3};
    tbl[5]  = '{0,0,0,0,0,0,0,1, 5,10, 0,1,3};
    tbl[6]  = '{0,0,0,0,0,0,0,1, 5, 7, 0,1,3};
    tbl[7]  = '{1,1,0,0,0,0,1,1, 9,15, 0,1,3};
    tbl[8]  = '{0,0,0,0,0,0,1,1, 9, 0, 0,1,4};
    tbl[9]  = '{0,0,0,0,0,0,1,0, 9,12, 0,1,4};
    tbl[10] = '{0,0,1,0,0,0,1,1, 9, 0, 0,1,5};
    tbl[11] = '{0,0,0,0,0,0,1,1, 9,15, 0,1,6};
    tbl[12] = '{0,1,0,0,0,0,1,1,15,15, 0,1,7};
    tbl[13] = '{0,0,1,1,0,0,1,1,15,15, 0,1,8};
    tbl[14] = '{0,0,0,0,0,0,1,1,15, 0, 0,1,9};
    tbl[15] = '{0,1,1,1,0,0,1,1, 3, 0, 0,1,10};
    tbl[16] = '{0,0,0,0,0,0,1,1, 3, 3, 0,1,11};

    CLR_N = 1'b0;
    ctl(0,0,0,0,0,0,0,0,0);
    Q = '0;
    repeat (2) @(posedge CLK);
    #1;
    model_reset();
    check_all("reset");
    #4 CLR_N = 1'b1;

    // Clear to sync, then count up with a correct counter.
    ctl(1,0,0,0,0,0,1,1,0);
    tick("b_clr", 0);
    for (int i = 0; i < 20; i++) begin
      ctl(0,0,1,1,0,0,1,1,0);
      tick("b_up", i % 16);
    end
    chk("b.synced", int'(synced_o[0]), 1);
    chk("b.chk_cnt", int'(ccnt_o[0]), 20);
    chk("b.sticky", int'(sticky_o[0]), 0);

    // Load 6, count down, inject 3 where 2 is due.
    ctl(0,1,0,0,0,0,1,1,6);
    tick("c_load", 4);
    for (int k = 0; k < 8; k++) begin
      ctl(0,0,1,0,0,0,1,1,6);
      tick("c_down", (k == 4) ? 3 : (6 - k + 16) % 16);
      if (k == 4) begin
        chk("c.err", int'(err_o[0]), 1);
        chk("c.err_cnt", int'(ecnt_o[0]), 1);
        chk("c.exp_first", int'(efirst_o[0]), 2);
        chk("c.obs_first", int'(ofirst_o[0]), 3);
      end
      if (k == 5) chk("c.err_pulse", int'(err_o[0]), 0);
    end

    // Hold with CE low, then a Q that moves during the hold.
    for (int k = 0; k < 6; k++) begin
      ctl(0,0,0,0,0,0,1,1,0);
      tick("d_hold", 14);
    end
    chk("d.hold_err_cnt", int'(ecnt_o[0]), 1);
    tick("d_move", 13);
    chk("d.move_err", int'(err_o[0]), 1);
    chk("d.move_err_cnt", int'(ecnt_o[0]), 2);

    async_reset();
    for (int r = 0; r < 17; r++) begin
      ctl(tbl[r].clr, tbl[r].load, tbl[r].ce, tbl[r].dir, tbl[r].sel, tbl[r].le,
          tbl[r].oe, tbl[r].en, tbl[r].data);
      tick($sformatf("tbl%0d", r), tbl[r].q);
      chk($sformatf("tbl%0d.err", r),    int'(err_o[0]),    tbl[r].e_err);
      chk($sformatf("tbl%0d.ecnt", r),   int'(ecnt_o[0]),   tbl[r].e_ecnt);
      chk($sformatf("tbl%0d.ccnt", r),   int'(ccnt_o[0]),   tbl[r].e_ccnt);
      chk($sformatf("tbl%0d.synced", r), int'(synced_o[0]), 1);
    end
    chk("tbl.exp_first", int'(efirst_o[0]), 1);
    chk("tbl.obs_first", int'(ofirst_o[0]), 5);

    // Halt-on-error: one mismatch, then ten more bad cycles.
    async_reset();
    ctl(1,0,0,0,0,0,1,1,0);
    tick("f_clr", 0);
    for (int k = 0; k < 3; k++) begin
      ctl(0,0,1,1,0,0,1,1,0);
      tick("f_good", k);
    end
    tick("f_bad", 7);
    for (int k = 0; k < 10; k++) tick("f_more", (k + 12) % 16);
    chk("f.halt_err_cnt", int'(ecnt_o[1]), 1);
    chk("f.halt_chk_cnt", int'(ccnt_o[1]), 4);
    chk("f.halt_synced", int'(synced_o[1]), 1);
    chk("f.halt_err", int'(err_o[1]), 0);
    chk("f.run_err_cnt", int'(ecnt_o[0]), 11);
    chk("f.run_chk_cnt", int'(ccnt_o[0]), 14);

    async_reset();
    for (int k = 0; k < 3; k++) begin
      ctl(0,0,1,1,0,0,1,1,0);
      tick("g_unsync", 9);
    end
    chk("g.synced", int'(synced_o[0]), 0);
    chk("g.chk_cnt", int'(ccnt_o[0]), 0);

    // Saturation of both counters.
    ctl(1,0,0,0,0,0,1,1,0);
    tick("s_clr", 0);
    for (int k = 0; k < 300; k++) begin
      ctl(0,0,1,1,0,0,1,1,0);
      tick("s_bad", good_q() ^ 1);
    end
    chk("s.err_cnt_sat", int'(ecnt_o[0]), CMAX);
    chk("s.chk_cnt_sat", int'(ccnt_o[0]), CMAX);

    // Randomized traffic against the reference.
    async_reset();
    for (int k = 0; k < 500; k++) begin
      ctl(($urandom_range(15) == 0), ($urandom_range(7) == 0), ($urandom_range(3) != 0),
          1'($urandom_range(1)), ($urandom_range(3) == 0), ($urandom_range(7) == 0),
          ($urandom_range(7) != 0), ($urandom_range(15) != 0), int'($urandom_range(15)));
      tick("rnd", ($urandom_range(9) == 0) ? int'($urandom_range(15)) : good_q());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
